if_fetch_ctrl: RTL and testbench
================================

# if_fetch_ctrl

Instruction-fetch responder for the MIPS pipeline. It consumes the address from the program counter, runs a req/ack transaction to instruction memory, and loads the returned word into the IF/ID pipeline register. It also drives the PC's enable, so the PC advances only when a fetch retires or a branch redirect occurs. The block absorbs variable memory latency, decode-stage stalls, and branch flushes.

## Interface
Parameters:
- RESET_INSTR, 32'h00000000 — bubble/NOP word loaded into IF/ID on reset, flush and bubbles

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous reset, active-high
- pc_addr  in  32  current PC value
- pc_enable  out  1  enable to PC; PC loads its input at the next edge when high
- flush  in  1  branch/jump taken; squash the fetch in flight and the IF/ID entry
- id_stall  in  1  decode stage stalled; IF/ID must hold
- mem_req  out  1  instruction memory request
- mem_addr  out  32  word-aligned fetch address
- mem_ack  in  1  memory accepts the request; mem_rdata is valid in the same cycle
- mem_rdata  in  32  instruction word
- ifid_instr  out  32  IF/ID instruction
- ifid_pc4  out  32  IF/ID PC+4
- ifid_valid  out  1  IF/ID holds a real instruction

## Operation
- States: IDLE, REQ, HOLD, DROP.
- IDLE:
  - If flush is low: latch pc_addr into addr_q and go to REQ.
  - If flush is high: pc_enable=1, stay in IDLE, do not latch (pc_addr is stale).
- REQ: mem_req=1, mem_addr={addr_q[31:2],2'b00}, both stable until ack.
  - ack & flush: discard data, pc_enable=1, go to IDLE.
  - ack & (!id_stall | !ifid_valid): load IF/ID with instr=mem_rdata, pc4=addr_q+4, valid=1; pc_enable=1; go to IDLE.
  - ack & id_stall & ifid_valid: capture mem_rdata into buf_q, go to HOLD, pc_enable=0.
  - !ack & flush: pc_enable=1, go to DROP.
- HOLD:
  - flush: discard buf_q, pc_enable=1, go to IDLE.
  - !id_stall: load IF/ID from buf_q and addr_q+4, pc_enable=1, go to IDLE.
  - Otherwise wait.
- DROP: mem_req=1 with the same addr_q. On ack, discard the data and go to IDLE. pc_enable=0 while in DROP.
- IF/ID update priority:
  - reset: valid=0, instr=RESET_INSTR, pc4=0.
  - Then flush: valid=0, instr=RESET_INSTR.
  - Then id_stall: hold.
  - Then load the fetched word if one retires this cycle, else load a bubble (valid=0, instr=RESET_INSTR).
- Arithmetic: pc4 is a 32-bit modulo add, so 0xFFFFFFFC+4=0x00000000. pc_addr[1:0] is ignored.

## Timing
- Reset values:
  - State IDLE.
  - mem_req=0, mem_addr=0, pc_enable=0.
  - ifid_valid=0, ifid_instr=RESET_INSTR, ifid_pc4=0.
  - addr_q=0, buf_q=0.
- pc_enable is combinational from state, mem_ack, flush and id_stall. It is never high in two consecutive cycles except under repeated flushes in IDLE.
- mem_req and mem_addr are registered: mem_req rises the cycle after IDLE.
- Best case, ack in the first REQ cycle:
  - cycle 0: IDLE.
  - cycle 1: REQ+ack, pc_enable=1.
  - cycle 2: ifid_valid=1, new pc_addr, IDLE.
  - Throughput is 1 instruction per 2 cycles.
- mem_req never drops without an ack, except on reset. The memory shares the same reset, so it abandons the request on reset.
- Reset mid-transaction takes effect at the next edge with no ack required.
- Simultaneous flush and id_stall: flush wins, IF/ID is squashed.

## Structure
- Shared package if_pkg holds:
  - state enum fetch_state_t (IDLE, REQ, HOLD, DROP)
  - constants NOP_INSTR=32'h00000000 and PC_STEP=32'd4
- One sub-module, ifid_reg, is the IF/ID pipeline register. Inputs: load, flush, stall, d_instr, d_pc4, d_valid. Reset and priority are as above.
- The FSM, addr_q and buf_q live in the top level.

## Test plan
- Reset, pc_addr=0x00400000, ack on the 2nd REQ cycle with 0x20080005 → pc_enable pulses once in the ack cycle; next cycle ifid_instr=0x20080005, ifid_pc4=0x00400004, ifid_valid=1.
- IF/ID valid with id_stall=1, ack with 0x8D090000 → HOLD, pc_enable=0, IF/ID unchanged. Drop id_stall → IF/ID=0x8D090000 and pc_enable=1 that cycle.
- flush in REQ before ack → pc_enable=1, DROP, mem_req held. Ack with 0xDEADBEEF → word never reaches IF/ID, ifid_valid=0.
- flush and ack in the same cycle with 0x12345678 → discarded, IDLE next, ifid_valid=0.
- Address corner cases:
  - pc_addr=0xFFFFFFFC → ifid_pc4=0x00000000.
  - pc_addr=0x00000006 → mem_addr=0x00000004.
- reset asserted in REQ and in HOLD → next edge mem_req=0, ifid_valid=0, state IDLE; no ack needed.

Source files
------------

// File: rtl/if_pkg.sv
// Shared types and constants for the instruction-fetch front end.
package if_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      HOLD = 2'd2,
      DROP = 2'd3
   } fetch_state_t;

   localparam int unsigned XLEN = 32;

   localparam logic [XLEN-1:0] NOP_INSTR = 32'h00000000;
   localparam logic [XLEN-1:0] PC_STEP   = 32'd4;
   localparam logic [XLEN-1:0] WORD_MASK = 32'hFFFF_FFFC;

   // Instruction fetches are always word aligned; the low PC bits are dropped.
   function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
      return addr & WORD_MASK;
   endfunction

endpackage

// File: rtl/ifid_reg.sv
// IF/ID pipeline register: reset, then flush, then stall-hold, then load or bubble.
module ifid_reg
   import if_pkg::*;
#(
   parameter logic [31:0] RESET_INSTR = NOP_INSTR
)
(
   input  logic        clk,
   input  logic        reset,
   input  logic        load,
   input  logic        flush,
   input  logic        stall,
   input  logic [31:0] d_instr,
   input  logic [31:0] d_pc4,
   input  logic        d_valid,
   output logic [31:0] instr,
   output logic [31:0] pc4,
   output logic        valid
);

   always_ff @(posedge clk) begin
      if (reset) begin
         valid <= 1'b0;
         instr <= RESET_INSTR;
         pc4   <= '0;
      end else if (flush) begin
         valid <= 1'b0;
         instr <= RESET_INSTR;
      end else if (!stall) begin
         if (load) begin
            valid <= d_valid;
            instr <= d_instr;
            pc4   <= d_pc4;
         end else begin
            // No word retiring this cycle: insert a bubble, pc4 is left as is.
            valid <= 1'b0;
            instr <= RESET_INSTR;
         end
      end
   end

endmodule

// File: rtl/if_fetch_ctrl.sv
// Instruction-fetch responder: PC -> imem req/ack -> IF/ID, with stall buffering
// and flush squashing of in-flight fetches.
module if_fetch_ctrl
   import if_pkg::*;
#(
   parameter logic [31:0] RESET_INSTR = 32'h00000000
)
(
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] pc_addr,
   output logic        pc_enable,
   input  logic        flush,
   input  logic        id_stall,
   output logic        mem_req,
   output logic [31:0] mem_addr,
   input  logic        mem_ack,
   input  logic [31:0] mem_rdata,
   output logic [31:0] ifid_instr,
   output logic [31:0] ifid_pc4,
   output logic        ifid_valid
);

   localparam int unsigned AW = XLEN;

   fetch_state_t  state;
   fetch_state_t  state_n;
   logic [AW-1:0] addr_q;
   logic [AW-1:0] addr_n;
   logic [AW-1:0] buf_q;
   logic [AW-1:0] buf_n;
   logic          ifid_load;
   logic [AW-1:0] load_instr;
   logic [AW-1:0] fetch_pc4;
   logic          ifid_hold;

   assign fetch_pc4 = addr_q + PC_STEP;
   // Holding an empty IF/ID is pointless, so a stall only blocks a valid entry.
   assign ifid_hold = id_stall & ifid_valid;

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         addr_q   <= '0;
         buf_q    <= '0;
         mem_req  <= 1'b0;
         mem_addr <= '0;
      end else begin
         state    <= state_n;
         addr_q   <= addr_n;
         buf_q    <= buf_n;
         mem_req  <= (state_n == REQ) || (state_n == DROP);
         mem_addr <= addr_n;
      end
   end

   always_comb begin
      state_n    = state;
      addr_n     = addr_q;
      buf_n      = buf_q;
      pc_enable  = 1'b0;
      ifid_load  = 1'b0;
      load_instr = mem_rdata;

      case (state)
         IDLE: begin
            if (flush) begin
               pc_enable = 1'b1;
            end else begin
               addr_n  = word_align(pc_addr);
               state_n = REQ;
            end
         end
         REQ: begin
            if (mem_ack && !flush && ifid_hold) begin
               buf_n   = mem_rdata;
               state_n = HOLD;
            end else if (mem_ack) begin
               pc_enable = 1'b1;
               ifid_load = !flush;
               state_n   = IDLE;
            end else if (flush) begin
               // Request cannot be withdrawn; wait out the ack in DROP.
               pc_enable = 1'b1;
               state_n   = DROP;
            end
         end
         HOLD: begin
            if (flush) begin
               pc_enable = 1'b1;
               state_n   = IDLE;
            end else if (!id_stall) begin
               pc_enable  = 1'b1;
               ifid_load  = 1'b1;
               load_instr = buf_q;
               state_n    = IDLE;
            end
         end
         DROP: begin
            if (mem_ack) begin
               state_n = IDLE;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   ifid_reg #(
      .RESET_INSTR (RESET_INSTR)
   ) u_ifid_reg (
      .clk     (clk),
      .reset   (reset),
      .load    (ifid_load),
      .flush   (flush),
      .stall   (ifid_hold),
      .d_instr (load_instr),
      .d_pc4   (fetch_pc4),
      .d_valid (1'b1),
      .instr   (ifid_instr),
      .pc4     (ifid_pc4),
      .valid   (ifid_valid)
   );

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// Scoreboard bench for if_fetch_ctrl: directed scenarios then random traffic,
// checked against a transaction-level model of the fetch path.
module tb_if_fetch_ctrl;

   localparam logic [31:0] BUBBLE = 32'hA5A5_0000;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] pc_addr;
   logic        pc_enable;
   logic        flush;
   logic        id_stall;
   logic        mem_req;
   logic [31:0] mem_addr;
   logic        mem_ack;
   logic [31:0] mem_rdata;
   logic [31:0] ifid_instr;
   logic [31:0] ifid_pc4;
   logic        ifid_valid;

   always #5 clk = ~clk;

   if_fetch_ctrl #(
      .RESET_INSTR (BUBBLE)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .pc_addr    (pc_addr),
      .pc_enable  (pc_enable),
      .flush      (flush),
      .id_stall   (id_stall),
      .mem_req    (mem_req),
      .mem_addr   (mem_addr),
      .mem_ack    (mem_ack),
      .mem_rdata  (mem_rdata),
      .ifid_instr (ifid_instr),
      .ifid_pc4   (ifid_pc4),
      .ifid_valid (ifid_valid)
   );

   typedef struct packed {
      logic        valid;
      logic [31:0] instr;
      logic [31:0] pc4;
   } ifid_t;

   ifid_t exp_q[$];
   int    n_checks = 0;
   int    n_fail   = 0;

   // Reference model: visible IF/ID contents, one parked word, and whether the
   // outstanding memory request has been squashed by a redirect.
   ifid_t       m_ifid;
   ifid_t       m_buf;
   logic        m_buf_v;
   logic        m_killed;
   logic [31:0] m_req_addr;
   logic        m_req_prev;
   logic [31:0] m_prev_pc;
   logic        last_pe;
   logic        last_fl;
   logic        last_rst;
   logic [31:0] last_tgt;

   ifid_t mon_e;
   ifid_t mon_g;

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
      n_checks++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s: got %h want %h (t=%0t)", name, got, want, $time);
      end
   endtask

   // Monitor: every edge produces one IF/ID state to compare.
   always @(posedge clk) begin
      #1;
      if (exp_q.size() > 0) begin
         mon_e = exp_q.pop_front();
         mon_g = '{ifid_valid, ifid_instr, ifid_pc4};
         n_checks++;
         if (mon_g !== mon_e) begin
            n_fail++;
            $display("FAIL ifid: got v=%0b i=%h p=%h want v=%0b i=%h p=%h (t=%0t)",
                     mon_g.valid, mon_g.instr, mon_g.pc4,
                     mon_e.valid, mon_e.instr, mon_e.pc4, $time);
         end
      end
   end

   // One clock cycle of stimulus, entered and left at the falling edge.
   task automatic step(input logic rst, input logic fl, input logic st, input logic ak,
                       input logic [31:0] rd, input logic [31:0] tgt);
      logic  req;
      logic  ack_eff;
      logic  pe;
      logic  exp_pe;
      logic  retire;
      logic  killed0;
      ifid_t w;
      ifid_t nxt;

      // The PC loads a redirect target on flush, otherwise steps by 4.
      if (last_pe && !last_rst) pc_addr = last_fl ? last_tgt : pc_addr + 32'd4;

      req = mem_req;
      if (last_rst) begin
         check("rst_mem_req", 64'(mem_req), 64'd0);
         check("rst_mem_addr", 64'(mem_addr), 64'd0);
      end
      if (req && !m_req_prev) begin
         m_req_addr = m_prev_pc & 32'hFFFF_FFFC;
         check("req_addr", 64'(mem_addr), 64'(m_req_addr));
      end else if (req) begin
         check("req_addr_stable", 64'(mem_addr), 64'(m_req_addr));
      end
      m_req_prev = req;
      m_prev_pc  = pc_addr;

      ack_eff   = ak & req;
      reset     = rst;
      flush     = fl;
      id_stall  = st;
      mem_ack   = ack_eff;
      mem_rdata = rd;
      #1;
      pe = pc_enable;

      if (rst) begin
         m_ifid   = '{1'b0, BUBBLE, 32'd0};
         m_buf_v  = 1'b0;
         m_killed = 1'b0;
         nxt      = m_ifid;
      end else begin
         killed0 = m_killed;
         retire  = 1'b0;
         w       = m_ifid;
         if (ack_eff) begin
            if (!(fl || m_killed)) begin
               if (st && m_ifid.valid) begin
                  m_buf   = '{1'b1, rd, m_req_addr + 32'd4};
                  m_buf_v = 1'b1;
               end else begin
                  w      = '{1'b1, rd, m_req_addr + 32'd4};
                  retire = 1'b1;
               end
            end
            m_killed = 1'b0;
         end else begin
            if (req && fl) m_killed = 1'b1;
            if (m_buf_v && fl) begin
               m_buf_v = 1'b0;
            end else if (m_buf_v && !st) begin
               w       = m_buf;
               retire  = 1'b1;
               m_buf_v = 1'b0;
            end
         end
         // PC moves when a word retires, or on a redirect not already absorbed by a dropped fetch.
         exp_pe = retire || (fl && !killed0);
         check("pc_enable", 64'(pe), 64'(exp_pe));

         if (fl)                       nxt = '{1'b0, BUBBLE, m_ifid.pc4};
         else if (st && m_ifid.valid)  nxt = m_ifid;
         else if (retire)              nxt = w;
         else                          nxt = '{1'b0, BUBBLE, m_ifid.pc4};
         m_ifid = nxt;
      end
      exp_q.push_back(nxt);

      last_pe  = pe;
      last_fl  = fl;
      last_rst = rst;
      last_tgt = tgt;
      @(negedge clk);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      logic        r_rst;
      logic        r_ak;
      reset      = 1'b1;
      pc_addr    = 32'h0040_0000;
      flush      = 1'b0;
      id_stall   = 1'b0;
      mem_ack    = 1'b0;
      mem_rdata  = 32'd0;
      m_ifid     = '{1'b0, BUBBLE, 32'd0};
      m_buf      = '0;
      m_buf_v    = 1'b0;
      m_killed   = 1'b0;
      m_req_addr = 32'd0;
      m_req_prev = 1'b0;
      m_prev_pc  = 32'd0;
      last_pe    = 1'b0;
      last_fl    = 1'b0;
      last_rst   = 1'b1;
      last_tgt   = 32'd0;
      @(negedge clk);

      step(1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
      step(1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);

      // Fetch with ack in the second REQ cycle.
      step(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
      step(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
      step(1'b0, 1'b0, 1'b0, 1'b1, 32'h2008_0005, 32'd0);
      check("first_instr", 64'(ifid_instr), 64'h2008_0005);
      check("first_pc4", 64'(ifid_pc4), 64'h0040_0004);
      check("first_valid", 64'(ifid_valid), 64'd1);

      // Decode stall parks the returned word until released.
      step(1'b0, 1'b0, 1'b1, 1'b0, 32'd0, 32'd0);
      step(1'b0, 1'b0, 1'b1, 1'b1, 32'h8D09_0000, 32'd0);
      step(1'b0, 1'b0, 1'b1, 1'b0, 32'd0, 32'd0);
      check("hold_instr", 64'(ifid_instr), 64'h2008_0005);
      step(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
      check("release_instr", 64'(ifid_instr), 64'h8D09_0000);
      check("release_pc4", 64'(ifid_pc4), 64'h0040_0008);

      // Flush before ack: request persists, returned word is dropped.
      step(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
      step(1'b0, 1'b1, 1'b0, 1'b0, 32'd0, 32'h0040_1000);
      step(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
      check("drop_req_held", 64'(mem_req), 64'd1);
      step(1'b0, 1'b0, 1'b0, 1'b1, 32'hDEAD_BEEF, 32'd0);
      check("drop_valid", 64'(ifid_valid), 64'd0);
      check("drop_instr", 64'(ifid_instr), 64'(BUBBLE));

      // Flush coincident with ack; redirect to the top word of memory.
      step(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
      step(1'b0, 1'b1, 1'b0, 1'b1, 32'h1234_5678, 32'hFFFF_FFFC);
      check("ackflush_valid", 64'(ifid_valid), 64'd0);
      check("ackflush_idle", 64'(mem_req), 64'd0);

      // pc4 wraps at the top of the address space.
      step(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
      step(1'b0, 1'b0, 1'b0, 1'b1, 32'h0C10_0000, 32'd0);
      check("pc4_wrap", 64'(ifid_pc4), 64'd0);

      // Misaligned PC fetches the containing word.
      step(1'b0, 1'b1, 1'b0, 1'b0, 32'd0, 32'h0000_0006);
      step(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
      check("mem_addr_align", 64'(mem_addr), 64'h0000_0004);
      step(1'b0, 1'b0, 1'b0, 1'b1, 32'h03E0_0008, 32'd0);

      // Reset while a request is outstanding.
      step(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
      step(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
      step(1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
      check("rst_req_memreq", 64'(mem_req), 64'd0);
      check("rst_req_valid", 64'(ifid_valid), 64'd0);

      // Reset while a word is parked.
      step(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
      step(1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_1111, 32'd0);
      step(1'b0, 1'b0, 1'b1, 1'b0, 32'd0, 32'd0);
      step(1'b0, 1'b0, 1'b1, 1'b1, 32'h0000_2222, 32'd0);
      step(1'b0, 1'b0, 1'b1, 1'b0, 32'd0, 32'd0);
      step(1'b1, 1'b0, 1'b1, 1'b0, 32'd0, 32'd0);
      check("rst_hold_memreq", 64'(mem_req), 64'd0);
      check("rst_hold_valid", 64'(ifid_valid), 64'd0);
      step(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
      check("post_rst_fetch", 64'(mem_req), 64'd1);

      // Random traffic: variable latency, stalls, flushes, occasional reset.
      for (int i = 0; i < 3000; i++) begin
         r_rst = ($urandom_range(0, 299) == 0);
         r_ak  = r_rst ? 1'b0 : 1'($urandom_range(0, 1));
         step(r_rst, 1'($urandom_range(0, 9) == 0), 1'($urandom_range(0, 2) == 0),
              r_ak, $urandom, $urandom);
      end
      for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b0, 1'b1, $urandom, 32'd0);

      check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
